// File: rtl/decade_counter_bcd.sv
// rtl/decade_counter_bcd.sv - single-digit BCD decade counter with clear, load and cascade terminal count
// Optional down-count direction input enabled by DECADE_COUNTER_BCD_DOWN_EN.
module decade_counter_bcd #(
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
`ifdef DECADE_COUNTER_BCD_DOWN_EN
    input  logic       dn,
`endif
    output logic [3:0] count,
    output logic       tc
);

    generate
        if (RESET_VALUE > 9) begin : g_bad_reset_value
            $error("decade_counter_bcd: RESET_VALUE must be in 0..9");
        end
    endgenerate

    localparam logic [3:0] RST_V = 4'(RESET_VALUE);

    logic [3:0] count_q;
    logic [3:0] count_d;
    logic       down;

`ifdef DECADE_COUNTER_BCD_DOWN_EN
    assign down = dn;
`else
    assign down = 1'b0;
`endif

    // Priority clr > load > en > hold; out-of-range loads collapse to 0 so the register stays BCD.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 4'd0;
        end else if (load) begin
            count_d = (load_val <= 4'd9) ? load_val : 4'd0;
        end else if (en) begin
            if (down) begin
                count_d = (count_q == 4'd0) ? 4'd9 : count_q - 4'd1;
            end else begin
                count_d = (count_q == 4'd9) ? 4'd0 : count_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= RST_V;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = en & (down ? (count_q == 4'd0) : (count_q == 4'd9));

endmodule

// File: tb/tb_decade_counter_bcd.sv
// tb/tb_decade_counter_bcd.sv - directed self-checking bench for decade_counter_bcd
module tb_decade_counter_bcd;

    logic       clock;
    logic       reset_n;
    logic       en;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       dn;
    logic [3:0] count;
    logic       tc;
    logic [3:0] count5;
    logic       tc5;

    logic       casc_en;
    logic       zero;
    logic [3:0] zero4;
    logic [3:0] units;
    logic       units_tc;
    logic [3:0] tens;
    logic       tens_tc;

    int checks = 0;
    int errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    decade_counter_bcd dut (
        .clock(clock), .reset_n(reset_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
`ifdef DECADE_COUNTER_BCD_DOWN_EN
        .dn(dn),
`endif
        .count(count), .tc(tc)
    );

    decade_counter_bcd #(.RESET_VALUE(5)) dut5 (
        .clock(clock), .reset_n(reset_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
`ifdef DECADE_COUNTER_BCD_DOWN_EN
        .dn(dn),
`endif
        .count(count5), .tc(tc5)
    );

    decade_counter_bcd u_units (
        .clock(clock), .reset_n(reset_n), .en(casc_en), .clr(zero), .load(zero), .load_val(zero4),
`ifdef DECADE_COUNTER_BCD_DOWN_EN
        .dn(zero),
`endif
        .count(units), .tc(units_tc)
    );

    decade_counter_bcd u_tens (
        .clock(clock), .reset_n(reset_n), .en(units_tc), .clr(zero), .load(zero), .load_val(zero4),
`ifdef DECADE_COUNTER_BCD_DOWN_EN
        .dn(zero),
`endif
        .count(tens), .tc(tens_tc)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n  = 1'b1;
        en       = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        dn       = 1'b0;
        casc_en  = 1'b0;
        zero     = 1'b0;
        zero4    = 4'd0;

        #1 reset_n = 1'b0;
        #1;
        check("reset_count", 8'(count), 8'd0);
        check("reset_tc", 8'(tc), 8'd0);
        check("reset_count_rv5", 8'(count5), 8'd5);
        check("reset_cascade", {tens, units}, 8'h00);

        step();
        check("held_in_reset", 8'(count), 8'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 2; i++) begin
            step();
            check("en_low_hold", 8'(count), 8'd0);
        end

        en = 1'b1;
        #1;
        for (int i = 1; i <= 11; i++) begin
            check("tc_before_step", 8'(tc), ((i - 1) % 10 == 9) ? 8'd1 : 8'd0);
            step();
            check("up_count", 8'(count), 8'(i % 10));
        end

        en = 1'b0; load = 1'b1; load_val = 4'd9;
        step();
        check("load_9", 8'(count), 8'd9);
        load = 1'b0;
        #1;
        check("tc_en_low_at_9", 8'(tc), 8'd0);
        step();
        check("hold_at_9", 8'(count), 8'd9);
        en = 1'b1;
        #1;
        check("tc_at_9", 8'(tc), 8'd1);
        step();
        check("wrap_to_0", 8'(count), 8'd0);
        check("tc_after_wrap", 8'(tc), 8'd0);
        en = 1'b0;

        load = 1'b1; load_val = 4'd7;
        step();
        check("load_7", 8'(count), 8'd7);
        load_val = 4'd12;
        step();
        check("load_12_to_0", 8'(count), 8'd0);
        load_val = 4'd15;
        step();
        check("load_15_to_0", 8'(count), 8'd0);
        load_val = 4'd5; clr = 1'b1;
        step();
        check("clr_beats_load", 8'(count), 8'd0);
        clr = 1'b0; load_val = 4'd3;
        step();
        check("load_3", 8'(count), 8'd3);
        en = 1'b1;
        step();
        check("load_beats_en", 8'(count), 8'd3);
        load = 1'b0; clr = 1'b1;
        step();
        check("clr_beats_en", 8'(count), 8'd0);
        clr = 1'b0; en = 1'b0;

        load = 1'b1; load_val = 4'd6;
        step();
        load = 1'b0;
        check("pre_reset_6", 8'(count), 8'd6);
        check("pre_reset_6_rv5", 8'(count5), 8'd6);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset", 8'(count), 8'd0);
        check("async_reset_rv5", 8'(count5), 8'd5);
        reset_n = 1'b1;
        en = 1'b1;
        step();
        check("resume_after_reset", 8'(count), 8'd1);
        check("resume_after_reset_rv5", 8'(count5), 8'd6);
        en = 1'b0;

        casc_en = 1'b1;
        #1;
        for (int i = 0; i < 100; i++) begin
            check("cascade", {tens, units}, 8'((i / 10) * 16 + (i % 10)));
            step();
        end
        check("cascade_wrap", {tens, units}, 8'h00);
        casc_en = 1'b0;

`ifdef DECADE_COUNTER_BCD_DOWN_EN
        load = 1'b1; load_val = 4'd2;
        step();
        load = 1'b0; dn = 1'b1; en = 1'b1;
        #1;
        check("dn_tc_at_2", 8'(tc), 8'd0);
        step();
        check("dn_1", 8'(count), 8'd1);
        check("dn_tc_at_1", 8'(tc), 8'd0);
        step();
        check("dn_0", 8'(count), 8'd0);
        check("dn_tc_at_0", 8'(tc), 8'd1);
        step();
        check("dn_wrap_9", 8'(count), 8'd9);
        check("dn_tc_at_9", 8'(tc), 8'd0);
        step();
        check("dn_8", 8'(count), 8'd8);
        en = 1'b0; dn = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
